// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// It uses a shift-add multiplier and a restoring divider, one bit per cycle, then a sign-fix/write-back cycle.
module muldiv_unit #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             divzero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t state, state_next;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] qreg;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] araw;
  logic             neg_main;
  logic             neg_rem;
  logic             is_div;
  logic             dz;

  logic             signed_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign busy = (state != IDLE);

  // Operand conditioning: iterations always run on magnitudes.
  always_comb begin
    signed_op = SIGNED_EN && op[0];
    a_neg     = signed_op && a[WIDTH-1];
    b_neg     = signed_op && b[WIDTH-1];
    a_abs     = a_neg ? -a : a;
    b_abs     = b_neg ? -b : b;
  end

  always_comb begin
    addend    = qreg[0] ? operand : '0;
    mul_sum   = {1'b0, acc} + {1'b0, addend};
    div_shift = {acc, qreg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, operand};
    prod      = {acc, qreg};
    prod_fix  = neg_main ? -prod : prod;
    quo_fix   = neg_main ? -qreg : qreg;
    rem_fix   = neg_rem ? -acc : acc;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start && !flush && !op[2])
          state_next = op[1] ? DIV : MUL;
      end
      MUL, DIV: begin
        if (flush)                 state_next = IDLE;
        else if (cnt == CW'(1))    state_next = FIX;
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      divzero  <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      qreg     <= '0;
      operand  <= '0;
      araw     <= '0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      is_div   <= 1'b0;
      dz       <= 1'b0;
    end else begin
      done    <= 1'b0;
      divzero <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            case (op)
              3'b000, 3'b001, 3'b010, 3'b011: begin
                acc      <= '0;
                qreg     <= a_abs;
                operand  <= b_abs;
                araw     <= a;
                cnt      <= CW'(WIDTH);
                neg_main <= a_neg ^ b_neg;
                neg_rem  <= a_neg;
                is_div   <= op[1];
                dz       <= (b == '0);
              end
              3'b100:  hi <= a;
              3'b101:  lo <= a;
              default: ;
            endcase
          end
        end
        MUL: begin
          if (!flush) begin
            acc  <= mul_sum[WIDTH:1];
            qreg <= {mul_sum[0], qreg[WIDTH-1:1]};
            cnt  <= cnt - CW'(1);
          end
        end
        DIV: begin
          if (!flush) begin
            // Restore by simply keeping the shifted value when the trial subtract underflows.
            if (!div_diff[WIDTH]) begin
              acc  <= div_diff[WIDTH-1:0];
              qreg <= {qreg[WIDTH-2:0], 1'b1};
            end else begin
              acc  <= div_shift[WIDTH-1:0];
              qreg <= {qreg[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt - CW'(1);
          end
        end
        FIX: begin
          if (!flush) begin
            done <= 1'b1;
            if (!is_div) begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end else if (dz) begin
              hi      <= araw;
              lo      <= '1;
              divzero <= 1'b1;
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table plus hand-written multi-cycle sequences.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, divzero;
  logic [31:0] hi, lo;

  logic        start8 = 1'b0;
  logic        flush8 = 1'b0;
  logic [2:0]  op8 = 3'b000;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        busy8, done8, divzero8;
  logic [7:0]  hi8, lo8;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32), .SIGNED_EN(1)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .divzero(divzero), .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(8), .SIGNED_EN(0)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .flush(flush8), .busy(busy8), .done(done8), .divzero(divzero8), .hi(hi8), .lo(lo8)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
    logic        expDz;
  } vec_t;

  vec_t vecs[12];

  int          checks = 0;
  int          errors = 0;
  int          latency;
  logic        busyAfter;
  logic        holdOk;
  logic        sawDone;
  logic [31:0] prevHi, prevLo;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic issueOnly(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitDone();
    latency = 0;
    holdOk  = 1'b1;
    while (!done && latency < 100) begin
      if (hi !== prevHi || lo !== prevLo) holdOk = 1'b0;
      @(posedge clk); #1;
      latency++;
    end
  endtask

  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    prevHi = hi; prevLo = lo;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busyAfter = busy;
    waitDone();
  endtask

  task automatic applyStimulus8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    op8 = o; a8 = x; b8 = y; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    latency = 0;
    while (!done8 && latency < 100) begin
      @(posedge clk); #1;
      latency++;
    end
  endtask

  initial begin
    vecs[0]  = '{3'b000, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b0};
    vecs[1]  = '{3'b001, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[2]  = '{3'b011, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{3'b010, 32'h0000000A, 32'h00000000, 32'h0000000A, 32'hFFFFFFFF, 1'b1};
    vecs[4]  = '{3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5]  = '{3'b010, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
    vecs[6]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[7]  = '{3'b011, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[8]  = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[9]  = '{3'b011, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};
    vecs[10] = '{3'b001, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0};
    vecs[11] = '{3'b010, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset hi", hi, 32'h0);
    checkOutput("reset lo", lo, 32'h0);
    checkOutput("reset busy", {31'b0, busy}, 32'h0);
    checkOutput("reset done", {31'b0, done}, 32'h0);
    checkOutput("reset divzero", {31'b0, divzero}, 32'h0);
    checkOutput("reset8 hi", {24'b0, hi8}, 32'h0);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      checkOutput($sformatf("v%0d busy", i), {31'b0, busyAfter}, 32'h1);
      checkOutput($sformatf("v%0d latency", i), latency, 32'd33);
      checkOutput($sformatf("v%0d hold", i), {31'b0, holdOk}, 32'h1);
      checkOutput($sformatf("v%0d hi", i), hi, vecs[i].expHi);
      checkOutput($sformatf("v%0d lo", i), lo, vecs[i].expLo);
      checkOutput($sformatf("v%0d divzero", i), {31'b0, divzero}, {31'b0, vecs[i].expDz});
      @(posedge clk); #1;
      checkOutput($sformatf("v%0d done pulse", i), {31'b0, done}, 32'h0);
      checkOutput($sformatf("v%0d busy end", i), {31'b0, busy}, 32'h0);
    end

    // Back-to-back: a start raised during the done cycle is taken on the next edge.
    applyStimulus(3'b000, 32'd2, 32'd3);
    checkOutput("b2b first lo", lo, 32'd6);
    applyStimulus(3'b000, 32'd4, 32'd5);
    checkOutput("b2b busy", {31'b0, busyAfter}, 32'h1);
    checkOutput("b2b latency", latency, 32'd33);
    checkOutput("b2b lo", lo, 32'd20);

    // MTHI during a running MULTU is ignored; MTLO afterwards takes one cycle.
    issueOnly(3'b100, 32'hCAFE0000, 32'h0);
    prevHi = hi; prevLo = lo;
    issueOnly(3'b000, 32'd3, 32'd5);
    repeat (4) @(posedge clk);
    issueOnly(3'b100, 32'h00001234, 32'h0);
    waitDone();
    checkOutput("ignored mthi latency", latency, 32'd28);
    checkOutput("ignored mthi hi", hi, 32'h0);
    checkOutput("ignored mthi lo", lo, 32'd15);
    @(posedge clk); #1;
    issueOnly(3'b101, 32'h00000055, 32'h0);
    checkOutput("mtlo lo", lo, 32'h55);
    checkOutput("mtlo hi", hi, 32'h0);
    checkOutput("mtlo done", {31'b0, done}, 32'h0);
    checkOutput("mtlo busy", {31'b0, busy}, 32'h0);
    issueOnly(3'b100, 32'hAAAA0000, 32'h0);
    checkOutput("mthi hi", hi, 32'hAAAA0000);
    checkOutput("mthi lo", lo, 32'h55);

    // Op 11x is a no-op.
    issueOnly(3'b110, 32'hDEADBEEF, 32'h1);
    checkOutput("noop busy", {31'b0, busy}, 32'h0);
    checkOutput("noop hi", hi, 32'hAAAA0000);
    checkOutput("noop lo", lo, 32'h55);

    // Flush mid-iteration aborts with no write and no done.
    issueOnly(3'b000, 32'd7, 32'd9);
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    checkOutput("flush busy", {31'b0, busy}, 32'h0);
    checkOutput("flush hi", hi, 32'hAAAA0000);
    checkOutput("flush lo", lo, 32'h55);
    sawDone = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) sawDone = 1'b1;
    end
    checkOutput("flush no done", {31'b0, sawDone}, 32'h0);

    // Flush on the write-back edge suppresses the write.
    issueOnly(3'b000, 32'd7, 32'd9);
    repeat (32) @(posedge clk);
    #1;
    checkOutput("fix busy before flush", {31'b0, busy}, 32'h1);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    checkOutput("fix flush done", {31'b0, done}, 32'h0);
    checkOutput("fix flush busy", {31'b0, busy}, 32'h0);
    checkOutput("fix flush lo", lo, 32'h55);
    checkOutput("fix flush hi", hi, 32'hAAAA0000);

    // Flush together with start in IDLE: the start is dropped.
    @(negedge clk);
    op = 3'b000; a = 32'd7; b = 32'd9; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    checkOutput("idle flush start busy", {31'b0, busy}, 32'h0);

    // Reset mid-operation clears everything.
    issueOnly(3'b000, 32'd7, 32'd9);
    repeat (9) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    checkOutput("midreset hi", hi, 32'h0);
    checkOutput("midreset lo", lo, 32'h0);
    checkOutput("midreset busy", {31'b0, busy}, 32'h0);
    checkOutput("midreset done", {31'b0, done}, 32'h0);
    checkOutput("midreset divzero", {31'b0, divzero}, 32'h0);

    // Narrow unsigned-only instance: MULT and DIV run unsigned.
    applyStimulus8(3'b001, 8'hFF, 8'hFF);
    checkOutput("w8 mult latency", latency, 32'd9);
    checkOutput("w8 mult hi", {24'b0, hi8}, 32'h000000FE);
    checkOutput("w8 mult lo", {24'b0, lo8}, 32'h00000001);
    applyStimulus8(3'b011, 8'hF9, 8'h02);
    checkOutput("w8 div latency", latency, 32'd9);
    checkOutput("w8 div lo", {24'b0, lo8}, 32'h0000007C);
    checkOutput("w8 div hi", {24'b0, hi8}, 32'h00000001);
    checkOutput("w8 div divzero", {31'b0, divzero8}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers. It replaces the single-cycle, incomplete hilo path in the ALU.
- Sits beside the ALU in the execute stage. The controller issues an operation with a one-cycle start pulse, stalls on busy, and reads hi/lo for mfhi/mflo.
- Processes one bit per cycle: a shift-add multiplier and a restoring divider.
- Generalised in operand width, with signed/unsigned multiply and divide, plus mthi, mtlo and flush.

Parameters:
- WIDTH, 32, operand/HI/LO width; legal values are 4 or more.
- SIGNED_EN, 1, when 1 ops MULT/DIV are signed; when 0 they execute as MULTU/DIVU.

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request, sampled only while idle.
- op  in  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 11x no-op.
- a  in  WIDTH  multiplicand/dividend/move source, sampled with start.
- b  in  WIDTH  multiplier/divisor, sampled with start.
- flush  in  1  abort the in-flight operation (pipeline exception).
- busy  out  1  iterative operation in progress.
- done  out  1  one-cycle pulse, hi/lo just updated by a mul/div.
- divzero  out  1  one-cycle pulse with done when the divisor was 0.
- hi  out  WIDTH  HI register (product upper half / remainder).
- lo  out  WIDTH  LO register (product lower half / quotient).

Behaviour:
- Reset: state IDLE; hi=0, lo=0, busy=0, done=0, divzero=0; any in-flight operation is discarded. Reset has priority over flush and start.
- States:
  - IDLE: accepts start.
  - MUL: iterates.
  - DIV: iterates.
  - FIX: sign correction and write-back.
- Timing for a mul/div start at edge E0:
  - Operands are latched at E0. If signed, absolute values are latched and the result sign is recorded. busy goes to 1 after E0.
  - Edges E1..E_WIDTH: one iteration each. An internal counter of ceil(log2(WIDTH+1)) bits counts down from WIDTH.
  - Edge E(WIDTH+1): FIX applies negation where needed, writes hi/lo, pulses done (and divzero if applicable), and returns to IDLE with busy=0.
  - Total latency is WIDTH+1 cycles. A new start is accepted on the edge after done.
- hi/lo hold their previous architectural values throughout MUL/DIV/FIX until the E(WIDTH+1) write. Intermediate values live in private registers.
- Multiply: the 2*WIDTH-bit product goes to {hi,lo}. For signed ops, the product is two's-complement negated when exactly one operand is negative.
- Divide: lo = quotient, hi = remainder.
  - Signed quotient is negated when the operand signs differ. The remainder takes the sign of the dividend.
  - Most-negative / -1 yields lo = most-negative (wraps), hi = 0.
- Divide by zero: no error stall. The full latency is still used. Results are lo = all ones, hi = a (raw input value); divzero=1 with done.
- MTHI/MTLO: single-cycle. At E0 hi (or lo) <= a; the other register is unchanged. No busy, no done.
- start while busy (MUL/DIV/FIX): ignored, with no effect on the running operation. Op 11x: ignored.
- flush while busy: at that edge return to IDLE. hi/lo are unchanged; busy=0; no done. flush in IDLE has no effect. Simultaneous flush and start in IDLE: start is ignored.
- flush on the FIX edge: the write is suppressed.
- done and divzero are registered outputs, high for exactly one cycle.

Test Plan:
- WIDTH=32, MULTU a=0xFFFFFFFF b=2 -> busy for 33 cycles; done at E33; hi=0x00000001, lo=0xFFFFFFFE; hi/lo keep prior values before E33.
- MULT a=-3 (0xFFFFFFFD) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=10 b=0 -> done at E33 with divzero=1; lo=0xFFFFFFFF, hi=0x0000000A. DIV a=0x80000000 b=-1 -> lo=0x80000000, hi=0.
- Issue MULTU, then pulse start with MTHI a=0x1234 at cycle 5 -> ignored, final hi = product. Afterwards MTLO a=0x55 -> lo=0x55 next cycle, done stays 0.
- MULTU in flight, flush at cycle 10 -> busy=0 next cycle, hi/lo unchanged, no done. Repeat with reset at cycle 10 -> hi=lo=0, all outputs 0.
- WIDTH=8, SIGNED_EN=0: MULT a=0xFF b=0xFF -> treated as unsigned; done after 9 cycles; hi=0xFE, lo=0x01.
